// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad code-entry block: key codes, FSM states
// and the BCD digit type.
package keypad_pkg;

  // Default control key codes as produced by the keypad scanner.
  localparam logic [7:0] KC_CLEAR = 8'h0A;
  localparam logic [7:0] KC_ENTER = 8'h0B;
  localparam logic [7:0] KC_BACK  = 8'h0C;

  // Key codes in this range are decimal digits.
  localparam logic [7:0] KC_DIGIT_MIN = 8'h00;
  localparam logic [7:0] KC_DIGIT_MAX = 8'h09;

  // ENTRY accepts keys; REBUILD recomputes the binary value after a
  // backspace; COMMIT is the single cycle following an accepted enter.
  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    REBUILD = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/dec_mac.sv
// Decimal multiply-accumulate: o_res = i_acc*10 + i_d, computed with
// shifts and adds, wrapping modulo 2^VAL_W.
module dec_mac
  import keypad_pkg::*;
#(
  parameter int VAL_W = 32
) (
  input  logic [VAL_W-1:0] i_acc,
  input  bcd_digit_t       i_d,
  output logic [VAL_W-1:0] o_res
);

  // acc*8 + acc*2 + digit
  assign o_res = (i_acc << 3) + (i_acc << 1) + VAL_W'(i_d);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code-entry buffer: accumulates decimal digits as packed BCD and as
// a binary value, with backspace, clear, enter/commit, digit limiting with a
// sticky overflow flag, and an inactivity auto-clear.
//
// key/key_valid handshake: key_valid is a level strobe with no ready; a key
// event is the rising edge of key_valid seen at a clock edge (key is sampled
// at that same edge). Events arriving outside ENTRY are dropped, and busy
// tells the scanner side when that is the case.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int               MAX_DIGITS     = 8,
  parameter int               KEY_W          = 8,
  parameter int               VAL_W          = 32,
  parameter int               TIMEOUT_CYCLES = 60_000_000,
  parameter logic [KEY_W-1:0] KEY_CLEAR      = KEY_W'(KC_CLEAR),
  parameter logic [KEY_W-1:0] KEY_ENTER      = KEY_W'(KC_ENTER),
  parameter logic [KEY_W-1:0] KEY_BACK       = KEY_W'(KC_BACK)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [KEY_W-1:0]                key,
  input  logic                            key_valid,
  output logic [4*MAX_DIGITS-1:0]         code_bcd,
  output logic [VAL_W-1:0]                code_bin,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count,
  output logic                            code_valid,
  output logic                            overflow,
  output logic                            timeout,
  output logic                            busy,
  output state_t                          dbg_state
);

  localparam int BCD_W  = 4 * MAX_DIGITS;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W  = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TERM   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t              r_state, w_state_n;
  logic [BCD_W-1:0]    r_bcd, w_bcd_n;
  logic [VAL_W-1:0]    r_bin, w_bin_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [IDX_W-1:0]    r_idx, w_idx_n;
  logic [IDLE_W-1:0]   r_idle, w_idle_n;
  logic                r_ovf, w_ovf_n;
  logic                r_valid, w_valid_n;
  logic                r_tmo, w_tmo_n;
  logic                r_key_q;

  logic                w_event;
  logic                w_is_digit;
  bcd_digit_t          w_nib;
  bcd_digit_t          w_mac_d;
  logic [VAL_W-1:0]    w_mac_res;

  assign w_event    = key_valid & ~r_key_q;
  assign w_is_digit = (key <= KEY_W'(KC_DIGIT_MAX));

  // Select the BCD nibble currently being folded back into the binary value.
  always_comb begin
    w_nib = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (IDX_W'(i) == r_idx) w_nib = r_bcd[4*i +: 4];
    end
  end

  // One multiply-accumulate unit shared by digit entry and REBUILD.
  assign w_mac_d = (r_state == REBUILD) ? w_nib : key[3:0];

  dec_mac #(
    .VAL_W (VAL_W)
  ) u_dec_mac (
    .i_acc (r_bin),
    .i_d   (w_mac_d),
    .o_res (w_mac_res)
  );

  // Next-state and next-datapath logic for the entry FSM.
  always_comb begin
    w_state_n = r_state;
    w_bcd_n   = r_bcd;
    w_bin_n   = r_bin;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_idle_n  = r_idle;
    w_ovf_n   = r_ovf;
    w_valid_n = 1'b0;
    w_tmo_n   = 1'b0;

    case (r_state)
      ENTRY: begin
        if (w_event) begin
          // Any key event, recognised or not, restarts the idle timer.
          w_idle_n = '0;
          if (w_is_digit) begin
            if (r_cnt < CNT_W'(MAX_DIGITS)) begin
              w_bcd_n = (r_bcd << 4) | BCD_W'(key[3:0]);
              w_bin_n = w_mac_res;
              w_cnt_n = r_cnt + CNT_W'(1);
            end else begin
              w_ovf_n = 1'b1;
            end
          end else if (key == KEY_BACK) begin
            if (r_cnt != '0) begin
              w_bcd_n = r_bcd >> 4;
              w_cnt_n = r_cnt - CNT_W'(1);
              w_bin_n = '0;
              if (r_cnt != CNT_W'(1)) begin
                // Rebuild starts at the most significant remaining nibble.
                w_idx_n   = IDX_W'(r_cnt - CNT_W'(2));
                w_state_n = REBUILD;
              end
            end
          end else if (key == KEY_CLEAR) begin
            w_bcd_n = '0;
            w_bin_n = '0;
            w_cnt_n = '0;
            w_ovf_n = 1'b0;
          end else if (key == KEY_ENTER) begin
            if (r_cnt != '0) begin
              w_valid_n = 1'b1;
              w_state_n = COMMIT;
            end
          end
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt != '0)) begin
          if (r_idle == IDLE_W'(TERM)) begin
            w_bcd_n  = '0;
            w_bin_n  = '0;
            w_cnt_n  = '0;
            w_ovf_n  = 1'b0;
            w_tmo_n  = 1'b1;
            w_idle_n = '0;
          end else begin
            w_idle_n = r_idle + IDLE_W'(1);
          end
        end else begin
          w_idle_n = '0;
        end
      end

      REBUILD: begin
        w_bin_n = w_mac_res;
        if (r_idx == '0) begin
          w_state_n = ENTRY;
        end else begin
          w_idx_n = r_idx - IDX_W'(1);
        end
      end

      COMMIT: begin
        w_bcd_n   = '0;
        w_bin_n   = '0;
        w_cnt_n   = '0;
        w_ovf_n   = 1'b0;
        w_idle_n  = '0;
        w_state_n = ENTRY;
      end

      default: begin
        w_state_n = ENTRY;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ENTRY;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_idle  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_key_q <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bcd   <= w_bcd_n;
      r_bin   <= w_bin_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_idle  <= w_idle_n;
      r_ovf   <= w_ovf_n;
      r_valid <= w_valid_n;
      r_tmo   <= w_tmo_n;
      r_key_q <= key_valid;
    end
  end

  assign code_bcd    = r_bcd;
  assign code_bin    = r_bin;
  assign digit_count = r_cnt;
  assign code_valid  = r_valid;
  assign overflow    = r_ovf;
  assign timeout     = r_tmo;
  assign busy        = (r_state != ENTRY);
  assign dbg_state   = r_state;

endmodule
